keccak_feed_controller: RTL and testbench

- Sequences the Keccak core from the AXI-Lite register file.
- Buffers words written to the INPUT register in a small FIFO, tags each with byte-count/last, and streams them to the core over a valid/ready handshake.
- Tracks hash progress, generates the core soft reset from the COMMAND register, and drives STATUS bits back to the register file.
- Sits between the register decode and the Keccak core, inside the peripheral's AXI clock domain.

---
 rtl/keccak_pkg.sv | 36 +++
 rtl/keccak_feed_controller_if.sv | 24 ++
 rtl/keccak_feed_fifo.sv | 67 ++++++
 rtl/keccak_feed_controller.sv | 131 +++++++++++++
 tb/tb_keccak_feed_controller.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types and constants for the Keccak feed controller
//
// Purpose: FSM state encoding, STATUS/CONTROL bit positions, word size and the
//          enqueue byte-count rule shared by the controller and its FIFO.
// Ports:   none (package).
package keccak_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ABSORB    = 2'd1,
    WAIT_HASH = 2'd2,
    DONE      = 2'd3
  } state_e;

  // STATUS register bit indices
  localparam int STATUS_DONE = 0;
  localparam int STATUS_BUSY = 1;
  localparam int STATUS_FULL = 2;
  localparam int STATUS_ERR  = 3;
  localparam int STATUS_W    = 4;

  // CONTROL register field positions
  localparam int CTRL_NBYTES_LSB = 0;
  localparam int CTRL_NBYTES_MSB = 1;
  localparam int CTRL_LAST       = 2;
  localparam int CTRL_W          = 3;

  localparam int WORD_BYTES = 4;

  // Non-final words are always full; the final word carries its own count,
  // where 0 denotes an empty final word.
  function automatic logic [2:0] enqueue_nbytes(input logic last, input logic [1:0] nbytes);
    return last ? {1'b0, nbytes} : 3'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/keccak_feed_controller_if.sv
// rtl/keccak_feed_controller_if.sv - word stream from the feed controller to the Keccak core
//
// Purpose: groups the valid/ready word handshake towards the core.
// Signals: core_valid/core_data/core_nbytes/core_last (controller -> core),
//          core_ready (core -> controller).
interface keccak_feed_controller_if #(
  parameter int DATA_W = 32
);
  logic              core_valid;
  logic              core_ready;
  logic [DATA_W-1:0] core_data;
  logic [2:0]        core_nbytes;
  logic              core_last;

  modport master (
    output core_valid, core_data, core_nbytes, core_last,
    input  core_ready
  );

  modport slave (
    input  core_valid, core_data, core_nbytes, core_last,
    output core_ready
  );
endinterface

// File: rtl/keccak_feed_fifo.sv
// rtl/keccak_feed_fifo.sv - synchronous FIFO of tagged input words with flush
//
// Purpose: DEPTH-entry FIFO of {data, nbytes, last} packed into WIDTH bits.
// Ports:   clk, resetn (sync active-low), flush (sync clear of pointers),
//          push/push_entry, pop, head_entry (current head), full, empty.
//          Caller must not push when full nor pop when empty; both are
//          also guarded here.
module keccak_feed_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_entry,
  input  logic             pop,
  output logic [WIDTH-1:0] head_entry,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_entry = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_entry;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/keccak_feed_controller.sv
// rtl/keccak_feed_controller.sv - sequences the Keccak core from the register file
//
// Purpose: buffers INPUT words in a FIFO tagged with byte count/last, streams
//          them to the core, tracks hash progress, issues the core soft reset
//          and reports STATUS.
// Ports:   S_AXI_ACLK, S_AXI_ARESETN (sync active-low);
//          cmd_reset, ctrl_nbytes, ctrl_last, in_wr, in_data from register decode;
//          core (stream master), core_soft_rst, core_done to/from the core;
//          st_done, st_busy, st_full, st_err back to STATUS.
module keccak_feed_controller
  import keccak_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic                       cmd_reset,
  input  logic [1:0]                 ctrl_nbytes,
  input  logic                       ctrl_last,
  input  logic                       in_wr,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       core_soft_rst,
  keccak_feed_controller_if.master   core,
  input  logic                       core_done,
  output logic                       st_done,
  output logic                       st_busy,
  output logic                       st_full,
  output logic                       st_err
);
  localparam int ENTRY_W = DATA_W + 4;

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   last_seen_q, last_seen_d;   // a last word has been enqueued this message
  logic   soft_rst_q, soft_rst_d;

  logic [CTRL_W-1:0]   ctrl;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic                fifo_full, fifo_empty;
  logic                push, pop, flush;
  logic                accepting;
  logic [STATUS_W-1:0] status;

  assign ctrl = {ctrl_last, ctrl_nbytes};
  assign push_entry = {in_data,
                       enqueue_nbytes(ctrl[CTRL_LAST], ctrl[CTRL_NBYTES_MSB:CTRL_NBYTES_LSB]),
                       ctrl[CTRL_LAST]};

  // Writes are only taken while a message is still open; full is judged on
  // the pre-dequeue occupancy, so a pop in the same cycle does not make room.
  assign accepting = ((state_q == IDLE) || (state_q == ABSORB)) && !last_seen_q;
  assign push      = in_wr && !cmd_reset && accepting && !fifo_full;
  assign flush     = cmd_reset;

  assign core.core_valid  = (state_q == ABSORB) && !fifo_empty;
  assign core.core_data   = head_entry[ENTRY_W-1:4];
  assign core.core_nbytes = head_entry[3:1];
  assign core.core_last   = head_entry[0];
  assign pop              = core.core_valid && core.core_ready;

  keccak_feed_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (S_AXI_ACLK),
    .resetn     (S_AXI_ARESETN),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    last_seen_d = last_seen_q;
    soft_rst_d  = 1'b0;

    unique case (state_q)
      IDLE:      if (push) state_d = ABSORB;
      ABSORB:    if (pop && core.core_last) state_d = WAIT_HASH;
      WAIT_HASH: if (core_done) state_d = DONE;
      DONE:      state_d = DONE;
      default:   state_d = IDLE;
    endcase

    if (push && ctrl[CTRL_LAST]) last_seen_d = 1'b1;
    if (in_wr && !cmd_reset && !push) err_d = 1'b1;

    // Command reset overrides everything, including a same-cycle write.
    if (cmd_reset) begin
      state_d     = IDLE;
      err_d       = 1'b0;
      last_seen_d = 1'b0;
      soft_rst_d  = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
      soft_rst_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      last_seen_q <= last_seen_d;
      soft_rst_q  <= soft_rst_d;
    end
  end

  always_comb begin
    status              = '0;
    status[STATUS_DONE] = (state_q == DONE);
    status[STATUS_BUSY] = (state_q == ABSORB) || (state_q == WAIT_HASH);
    status[STATUS_FULL] = fifo_full;
    status[STATUS_ERR]  = err_q;
  end

  assign st_done       = status[STATUS_DONE];
  assign st_busy       = status[STATUS_BUSY];
  assign st_full       = status[STATUS_FULL];
  assign st_err        = status[STATUS_ERR];
  assign core_soft_rst = soft_rst_q;
endmodule

// File: tb/tb_keccak_feed_controller.sv
// tb/tb_keccak_feed_controller.sv - self-checking bench for keccak_feed_controller
module tb_keccak_feed_controller;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nb;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_reset;
  logic [1:0]  ctrl_nbytes;
  logic        ctrl_last;
  logic        in_wr;
  logic [31:0] in_data;
  logic        core_soft_rst;
  logic        core_done;
  logic        st_done, st_busy, st_full, st_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  word_t got_q[$];

  keccak_feed_controller_if #(.DATA_W(32)) core_if ();

  keccak_feed_controller #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (resetn),
    .cmd_reset     (cmd_reset),
    .ctrl_nbytes   (ctrl_nbytes),
    .ctrl_last     (ctrl_last),
    .in_wr         (in_wr),
    .in_data       (in_data),
    .core_soft_rst (core_soft_rst),
    .core          (core_if.master),
    .core_done     (core_done),
    .st_done       (st_done),
    .st_busy       (st_busy),
    .st_full       (st_full),
    .st_err        (st_err)
  );

  always #5 clk = ~clk;

  // Records every word the core accepts; inputs only change at posedge+1.
  always @(negedge clk) begin
    if (resetn && core_if.core_valid && core_if.core_ready)
      got_q.push_back('{core_if.core_data, core_if.core_nbytes, core_if.core_last});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [2:0] v);
    ctrl_nbytes = v[1:0];
    ctrl_last   = v[2];
  endtask

  task automatic write_word(input logic [31:0] d);
    in_data = d;
    in_wr   = 1'b1;
    step();
    in_wr   = 1'b0;
  endtask

  task automatic pulse_cmd_reset();
    cmd_reset = 1'b1;
    step();
    cmd_reset = 1'b0;
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_reset = 1'b0; in_wr = 1'b0; in_data = '0;
    core_done = 1'b0; core_if.core_ready = 1'b0; set_ctrl(3'd0);
    step(); step();
    total_cnt++;
    if (core_soft_rst !== 1'b1) $display("FAIL reset_soft_rst: got %b want 1", core_soft_rst);
    else pass_cnt++;
    total_cnt++;
    if ({st_done, st_busy, st_full, st_err, core_if.core_valid, core_if.core_last,
         core_if.core_nbytes, core_if.core_data} !== '0)
      $display("FAIL reset_outputs: got st=%b%b%b%b v=%b data=%h want all 0",
               st_done, st_busy, st_full, st_err, core_if.core_valid, core_if.core_data);
    else pass_cnt++;
    resetn = 1'b1;
    step();
    total_cnt++;
    if (core_soft_rst !== 1'b0) $display("FAIL reset_release_soft_rst: got %b want 0", core_soft_rst);
    else pass_cnt++;
  endtask

  task automatic test_hello();
    word_t exp [3];
    bit ok;
    exp[0] = '{32'h48656C6C, 3'd4, 1'b0};
    exp[1] = '{32'h6F20576F, 3'd4, 1'b0};
    exp[2] = '{32'h726C6420, 3'd3, 1'b1};
    got_q.delete();
    core_if.core_ready = 1'b1;
    set_ctrl(3'd0);
    write_word(32'h48656C6C);
    total_cnt++;
    if (core_if.core_valid !== 1'b1) $display("FAIL hello_latency: core_valid got %b want 1", core_if.core_valid);
    else pass_cnt++;
    write_word(32'h6F20576F);
    set_ctrl(3'd7);
    write_word(32'h726C6420);
    wait_words(3, ok);
    total_cnt++;
    if (!ok || got_q.size() != 3) $display("FAIL hello_count: got %0d words want 3", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp[i]) $display("FAIL hello_word%0d: got %h/%0d/%b want %h/%0d/%b", i,
                                        got_q[i].data, got_q[i].nb, got_q[i].last,
                                        exp[i].data, exp[i].nb, exp[i].last);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({st_busy, st_done} !== 2'b10) $display("FAIL hello_wait_hash: busy/done got %b%b want 10", st_busy, st_done);
    else pass_cnt++;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    total_cnt++;
    if ({st_busy, st_done} !== 2'b01) $display("FAIL hello_done: busy/done got %b%b want 01", st_busy, st_done);
    else pass_cnt++;
    step();
    total_cnt++;
    if (st_done !== 1'b1) $display("FAIL hello_done_hold: got %b want 1", st_done);
    else pass_cnt++;
    pulse_cmd_reset();
    total_cnt++;
    if ({st_done, core_soft_rst} !== 2'b01) $display("FAIL hello_cmd_reset: done/soft_rst got %b%b want 01", st_done, core_soft_rst);
    else pass_cnt++;
    step();
    total_cnt++;
    if (core_soft_rst !== 1'b0) $display("FAIL hello_soft_rst_width: got %b want 0", core_soft_rst);
    else pass_cnt++;
  endtask

  task automatic test_empty_msg();
    bit ok;
    word_t exp;
    exp = '{32'h00AABBCC, 3'd0, 1'b1};
    got_q.delete();
    core_if.core_ready = 1'b1;
    set_ctrl(3'd4);
    write_word(32'h00AABBCC);
    wait_words(1, ok);
    total_cnt++;
    if (!ok || got_q[0] !== exp) $display("FAIL empty_msg: got ok=%b %h/%0d/%b want %h/0/1", ok,
                                          got_q.size() > 0 ? got_q[0].data : 32'h0,
                                          got_q.size() > 0 ? got_q[0].nb : 3'd0,
                                          got_q.size() > 0 ? got_q[0].last : 1'b0, exp.data);
    else pass_cnt++;
    pulse_cmd_reset();
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] w [5];
    bit ok;
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    got_q.delete();
    core_if.core_ready = 1'b0;
    set_ctrl(3'd0);
    for (int i = 0; i < 4; i++) write_word(w[i]);
    total_cnt++;
    if (st_full !== 1'b1) $display("FAIL overflow_full: got %b want 1", st_full);
    else pass_cnt++;
    write_word(w[4]);
    total_cnt++;
    if (st_err !== 1'b1) $display("FAIL overflow_err: got %b want 1", st_err);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if (core_if.core_valid !== 1'b1 || core_if.core_data !== w[0] || core_if.core_nbytes !== 3'd4)
        $display("FAIL overflow_hold%0d: got v=%b %h/%0d want v=1 %h/4", c,
                 core_if.core_valid, core_if.core_data, core_if.core_nbytes, w[0]);
      else pass_cnt++;
      step();
    end
    core_if.core_ready = 1'b1;
    wait_words(4, ok);
    step(); step(); step();
    total_cnt++;
    if (got_q.size() != 4) $display("FAIL overflow_count: got %0d words want 4", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== word_t'{w[i], 3'd4, 1'b0})
        $display("FAIL overflow_word%0d: got %h want %h", i, got_q[i].data, w[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (st_full !== 1'b0) $display("FAIL overflow_drained_full: got %b want 0", st_full);
    else pass_cnt++;
    pulse_cmd_reset();
    total_cnt++;
    if (st_err !== 1'b0) $display("FAIL overflow_err_clear: got %b want 0", st_err);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] last_d;
    int sent;
    last_d = $urandom;
    sent = 0;
    got_q.delete();
    set_ctrl(3'd0);
    for (int c = 0; c < 400 && got_q.size() < 21; c++) begin
      core_if.core_ready = c[0];
      if (c % 2 == 0 && sent < 21) begin
        if (sent == 20) set_ctrl(3'd4);
        in_data = (sent < 20) ? 32'h30303031 : last_d;
        in_wr = 1'b1;
        sent++;
      end else begin
        in_wr = 1'b0;
      end
      step();
    end
    in_wr = 1'b0;
    total_cnt++;
    if (got_q.size() != 21) $display("FAIL wrap_count: got %0d words want 21", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 21 && i < got_q.size(); i++) begin
      word_t e;
      e = (i < 20) ? word_t'{32'h30303031, 3'd4, 1'b0} : word_t'{last_d, 3'd0, 1'b1};
      total_cnt++;
      if (got_q[i] !== e) $display("FAIL wrap_word%0d: got %h/%0d/%b want %h/%0d/%b", i,
                                   got_q[i].data, got_q[i].nb, got_q[i].last, e.data, e.nb, e.last);
      else pass_cnt++;
    end
    total_cnt++;
    if (st_err !== 1'b0) $display("FAIL wrap_err: got %b want 0", st_err);
    else pass_cnt++;
    pulse_cmd_reset();
  endtask

  task automatic test_cmd_reset();
    bit ok;
    got_q.delete();
    core_if.core_ready = 1'b0;
    set_ctrl(3'd0);
    write_word($urandom);
    write_word($urandom);
    total_cnt++;
    if ({core_if.core_valid, st_busy} !== 2'b11) $display("FAIL cmdrst_pre: valid/busy got %b%b want 11", core_if.core_valid, st_busy);
    else pass_cnt++;
    pulse_cmd_reset();
    total_cnt++;
    if ({core_if.core_valid, st_busy, core_soft_rst} !== 3'b001)
      $display("FAIL cmdrst_after: valid/busy/soft_rst got %b%b%b want 001", core_if.core_valid, st_busy, core_soft_rst);
    else pass_cnt++;
    step();
    total_cnt++;
    if (core_soft_rst !== 1'b0) $display("FAIL cmdrst_pulse_width: got %b want 0", core_soft_rst);
    else pass_cnt++;
    write_word($urandom);
    in_data = $urandom; in_wr = 1'b1; cmd_reset = 1'b1;
    step();
    in_wr = 1'b0; cmd_reset = 1'b0;
    step();
    total_cnt++;
    if ({core_if.core_valid, st_busy, st_err} !== 3'b000)
      $display("FAIL cmdrst_with_write: valid/busy/err got %b%b%b want 000", core_if.core_valid, st_busy, st_err);
    else pass_cnt++;
    core_if.core_ready = 1'b1;
    set_ctrl(3'd6);
    write_word(32'h54686520);
    wait_words(1, ok);
    step(); step();
    total_cnt++;
    if (got_q.size() != 1 || got_q[0] !== word_t'{32'h54686520, 3'd2, 1'b1})
      $display("FAIL cmdrst_new_msg: got %0d words first %h/%0d/%b want 1 word 54686520/2/1", got_q.size(),
               got_q.size() > 0 ? got_q[0].data : 32'h0, got_q.size() > 0 ? got_q[0].nb : 3'd0,
               got_q.size() > 0 ? got_q[0].last : 1'b0);
    else pass_cnt++;
    pulse_cmd_reset();
  endtask

  task automatic test_write_after_last();
    bit ok;
    got_q.delete();
    core_if.core_ready = 1'b1;
    set_ctrl(3'd7);
    write_word($urandom);
    wait_words(1, ok);
    step();
    total_cnt++;
    if (st_err !== 1'b0) $display("FAIL wal_err_before: got %b want 0", st_err);
    else pass_cnt++;
    set_ctrl(3'd0);
    write_word($urandom);
    total_cnt++;
    if ({core_if.core_valid, st_err, st_busy} !== 3'b011)
      $display("FAIL wal_wait_hash: valid/err/busy got %b%b%b want 011", core_if.core_valid, st_err, st_busy);
    else pass_cnt++;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    write_word($urandom);
    step();
    total_cnt++;
    if ({st_done, core_if.core_valid} !== 2'b10 || got_q.size() != 1)
      $display("FAIL wal_done: done/valid got %b%b words %0d want 10 words 1", st_done, core_if.core_valid, got_q.size());
    else pass_cnt++;
    pulse_cmd_reset();
    total_cnt++;
    if ({st_err, st_done} !== 2'b00) $display("FAIL wal_err_clear: err/done got %b%b want 00", st_err, st_done);
    else pass_cnt++;
  endtask

  // Random messages checked against a queue model: a write is taken when the
  // message is open and fewer than DEPTH words are waiting (accepted minus
  // already consumed); anything else is dropped and flags the error.
  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      word_t exp_q[$];
      int accepted;
      bit last_acc, exp_err, ok;
      int cyc;
      accepted = 0; last_acc = 1'b0; exp_err = 1'b0; cyc = 0;
      got_q.delete();
      while (!last_acc && cyc < 300) begin
        core_if.core_ready = ($urandom_range(0, 2) != 0);
        core_done = ($urandom_range(0, 3) == 0);
        in_wr = $urandom_range(0, 1);
        in_data = $urandom;
        ctrl_last = ($urandom_range(0, 9) == 0) || (cyc > 200);
        ctrl_nbytes = $urandom_range(0, 3);
        if (in_wr) begin
          if (accepted - got_q.size() < DEPTH) begin
            exp_q.push_back('{in_data, ctrl_last ? {1'b0, ctrl_nbytes} : 3'd4, ctrl_last});
            accepted++;
            last_acc = ctrl_last;
          end else begin
            exp_err = 1'b1;
          end
        end
        step();
        cyc++;
      end
      in_wr = 1'b0; core_done = 1'b0; core_if.core_ready = 1'b1;
      wait_words(exp_q.size(), ok);
      step(); step();
      total_cnt++;
      if (got_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d words want %0d", m, got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total_cnt++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rand%0d_word%0d: got %h/%0d/%b want %h/%0d/%b", m, i,
                                            got_q[i].data, got_q[i].nb, got_q[i].last,
                                            exp_q[i].data, exp_q[i].nb, exp_q[i].last);
        else pass_cnt++;
      end
      total_cnt++;
      if ({st_err, st_done, st_busy} !== {exp_err, 2'b01})
        $display("FAIL rand%0d_status: err/done/busy got %b%b%b want %b01", m, st_err, st_done, st_busy, exp_err);
      else pass_cnt++;
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      total_cnt++;
      if (st_done !== 1'b1) $display("FAIL rand%0d_done: got %b want 1", m, st_done);
      else pass_cnt++;
      pulse_cmd_reset();
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_empty_msg();
    test_overflow();
    test_wrap();
    test_cmd_reset();
    test_write_after_last();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
